// File: rtl/clint_pkg.sv
// Shared clint types: initiator FSM states, AXI response codes and the
// AXI-Lite request/response channel structs used by axi_lite_initiator.
package clint_pkg;

  localparam int unsigned AXI_LITE_ADDR_W = 64;
  localparam int unsigned AXI_LITE_DATA_W = 64;
  localparam int unsigned AXI_LITE_ID_W   = 10;
  localparam int unsigned AXI_LITE_STRB_W = AXI_LITE_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_B,
    READ_A,
    READ_R
  } state_e;

  typedef struct packed {
    logic [AXI_LITE_ID_W-1:0]   id;
    logic [AXI_LITE_ADDR_W-1:0] addr;
    logic [2:0]                 prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [AXI_LITE_DATA_W-1:0] data;
    logic [AXI_LITE_STRB_W-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [AXI_LITE_ID_W-1:0] id;
    logic [1:0]               resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [AXI_LITE_ID_W-1:0]   id;
    logic [AXI_LITE_DATA_W-1:0] data;
    logic [1:0]                 resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_lite_b_t b;
    logic        r_valid;
    axi_lite_r_t r;
  } axi_lite_resp_t;

endpackage

// File: rtl/axi_lite_initiator.sv
// Converts a req/gnt/rvalid local port into single-outstanding AXI-Lite transactions.
// Define AXI_LITE_INITIATOR_RSP_REG_EN to register the completion outputs.
module axi_lite_initiator
  import clint_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter type         axi_req_t      = axi_lite_req_t,
  parameter type         axi_resp_t     = axi_lite_resp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output axi_req_t                    axi_req_o,
  input  axi_resp_t                   axi_resp_i
);

  state_e                      state_reg, state_next;
  logic                        aw_done_reg, aw_done_next;
  logic                        w_done_reg, w_done_next;
  logic [AXI_ADDR_WIDTH-1:0]   addr_reg;
  logic [AXI_DATA_WIDTH-1:0]   wdata_reg;
  logic [AXI_DATA_WIDTH/8-1:0] be_reg;
  logic                        latch_en;
  logic                        cpl_valid;
  logic                        cpl_err;
  logic [AXI_DATA_WIDTH-1:0]   cpl_data;
  logic                        unused_resp;

  // Response IDs and the low resp bit carry nothing for a single-ID initiator.
  assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.r.id,
                         axi_resp_i.b.resp[0], axi_resp_i.r.resp[0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      if (latch_en) begin
        addr_reg  <= addr_i;
        wdata_reg <= wdata_i;
        be_reg    <= be_i;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    latch_en     = 1'b0;
    gnt_o        = 1'b0;
    cpl_valid    = 1'b0;
    cpl_err      = 1'b0;
    cpl_data     = '0;
    axi_req_o    = '0;
    axi_req_o.aw.id = {AXI_ID_WIDTH{1'b0}};
    axi_req_o.ar.id = {AXI_ID_WIDTH{1'b0}};

    case (state_reg)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          latch_en   = 1'b1;
          state_next = we_i ? WRITE : READ_A;
        end
      end
      WRITE: begin
        // Valids come only from the done flags, never from the readies.
        axi_req_o.aw_valid = !aw_done_reg;
        axi_req_o.w_valid  = !w_done_reg;
        axi_req_o.aw.addr  = addr_reg;
        axi_req_o.w.data   = wdata_reg;
        axi_req_o.w.strb   = be_reg;
        if (axi_req_o.aw_valid && axi_resp_i.aw_ready) aw_done_next = 1'b1;
        if (axi_req_o.w_valid && axi_resp_i.w_ready) w_done_next = 1'b1;
        if (aw_done_next && w_done_next) state_next = WRITE_B;
      end
      WRITE_B: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_resp_i.b_valid) begin
          cpl_valid    = 1'b1;
          cpl_err      = axi_resp_i.b.resp[1];
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = IDLE;
        end
      end
      READ_A: begin
        axi_req_o.ar_valid = 1'b1;
        axi_req_o.ar.addr  = addr_reg;
        if (axi_resp_i.ar_ready) state_next = READ_R;
      end
      READ_R: begin
        axi_req_o.r_ready = 1'b1;
        if (axi_resp_i.r_valid) begin
          cpl_valid  = 1'b1;
          cpl_data   = axi_resp_i.r.data;
          cpl_err    = axi_resp_i.r.resp[1];
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef AXI_LITE_INITIATOR_RSP_REG_EN
  logic                      rvalid_reg;
  logic                      err_reg;
  logic [AXI_DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= cpl_valid;
      err_reg    <= cpl_err;
      rdata_reg  <= cpl_data;
    end
  end

  assign rvalid_o = rvalid_reg;
  assign err_o    = err_reg;
  assign rdata_o  = rdata_reg;
`else
  assign rvalid_o = cpl_valid;
  assign err_o    = cpl_err;
  assign rdata_o  = cpl_data;
`endif

endmodule
